// File: rtl/lsu_stage_if.sv
// EX request, RAM access and writeback signals of the load/store unit.
// The LSU takes the slave view; the execute/ram/writeback environment takes the master view.
interface lsu_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [7:0]  ex_opcode;
  logic [63:0] ex_addr;
  logic [63:0] ex_wdata;
  logic [4:0]  ex_rd;

  logic [7:0]  inst_opcode;
  logic [63:0] mem_addr;
  logic        mem_w_ena;
  logic [63:0] mem_w_data;
  logic        mem_r_ena;
  logic [63:0] mem_r_data;

  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic        wb_wen;
  logic [63:0] wb_data;
  logic        wb_misalign;

  modport slave (
    input  ex_valid, ex_opcode, ex_addr, ex_wdata, ex_rd,
    input  mem_r_data, wb_ready,
    output ex_ready, inst_opcode, mem_addr, mem_w_ena, mem_w_data, mem_r_ena,
    output wb_valid, wb_rd, wb_wen, wb_data, wb_misalign
  );

  modport master (
    output ex_valid, ex_opcode, ex_addr, ex_wdata, ex_rd,
    output mem_r_data, wb_ready,
    input  ex_ready, inst_opcode, mem_addr, mem_w_ena, mem_w_data, mem_r_ena,
    input  wb_valid, wb_rd, wb_wen, wb_data, wb_misalign
  );
endinterface

// File: rtl/lsu_stage.sv
// Load/store unit between EX and ram: one request in flight, sign-extends loads,
// flags misaligned/out-of-range accesses and hands results to writeback.
module lsu_stage #(
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [63:0] PC_START   = 64'h0000_0000_8000_0000
) (
  input logic        clk,
  input logic        rst,
  lsu_stage_if.slave bus
);

  localparam logic [7:0] INST_LB  = 8'h11;
  localparam logic [7:0] INST_LH  = 8'h12;
  localparam logic [7:0] INST_LW  = 8'h13;
  localparam logic [7:0] INST_LD  = 8'h14;
  localparam logic [7:0] INST_LBU = 8'h15;
  localparam logic [7:0] INST_LHU = 8'h16;
  localparam logic [7:0] INST_LWU = 8'h17;
  localparam logic [7:0] INST_SB  = 8'h21;
  localparam logic [7:0] INST_SH  = 8'h22;
  localparam logic [7:0] INST_SW  = 8'h23;
  localparam logic [7:0] INST_SD  = 8'h24;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  op_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [3:0]  cnt_q;
  logic [4:0]  rd_q;
  logic        wen_q;
  logic        mis_q;
  logic [63:0] data_q;

  logic        ex_ready;
  logic [7:0]  inst_opcode;
  logic [63:0] mem_addr;
  logic        mem_w_ena;
  logic [63:0] mem_w_data;
  logic        mem_r_ena;
  logic        wb_valid;

  logic        accept;
  logic        in_load;
  logic        in_store;
  logic        in_mem;
  logic        in_mis;

  function automatic logic is_load_op(input logic [7:0] op);
    return op inside {INST_LB, INST_LH, INST_LW, INST_LD, INST_LBU, INST_LHU, INST_LWU};
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    return op inside {INST_SB, INST_SH, INST_SW, INST_SD};
  endfunction

  function automatic logic misaligned(input logic [7:0] op, input logic [63:0] addr);
    logic m;
    m = (addr < PC_START);
    unique case (op)
      INST_LD, INST_SD:           if (addr[2:0] != 3'b000) m = 1'b1;
      INST_LW, INST_LWU, INST_SW: if (addr[1:0] != 2'b00)  m = 1'b1;
      INST_LH, INST_LHU, INST_SH: if (addr[0])             m = 1'b1;
      default:                    ;
    endcase
    return m;
  endfunction

  // ram returns lane-selected, zero-extended data; only the signed loads need work
  function automatic logic [63:0] extend(input logic [7:0] op, input logic [63:0] d);
    logic [63:0] r;
    unique case (op)
      INST_LB:  r = {{56{d[7]}},  d[7:0]};
      INST_LH:  r = {{48{d[15]}}, d[15:0]};
      INST_LW:  r = {{32{d[31]}}, d[31:0]};
      INST_LBU: r = {56'b0, d[7:0]};
      INST_LHU: r = {48'b0, d[15:0]};
      INST_LWU: r = {32'b0, d[31:0]};
      default:  r = d;
    endcase
    return r;
  endfunction

  assign accept   = bus.ex_valid && (state_q == IDLE);
  assign in_load  = is_load_op(bus.ex_opcode);
  assign in_store = is_store_op(bus.ex_opcode);
  assign in_mem   = in_load || in_store;
  // pass-through ops carry no address, so the range/alignment check is for memory ops only
  assign in_mis   = in_mem && misaligned(bus.ex_opcode, bus.ex_addr);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ex_ready    = 1'b0;
    inst_opcode = '0;
    mem_addr    = '0;
    mem_w_ena   = 1'b0;
    mem_w_data  = '0;
    mem_r_ena   = 1'b0;
    wb_valid    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ex_ready = 1'b1;
        if (bus.ex_valid) state_d = (in_mem && !in_mis) ? REQ : RESP;
      end
      REQ: begin
        inst_opcode = op_q;
        mem_addr    = addr_q;
        if (is_store_op(op_q)) begin
          mem_w_ena  = 1'b1;
          mem_w_data = wdata_q;
          state_d    = RESP;
        end else begin
          mem_r_ena = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        inst_opcode = op_q;
        mem_addr    = addr_q;
        mem_r_ena   = 1'b1;
        if (cnt_q == 4'd0) state_d = RESP;
      end
      RESP: begin
        wb_valid = 1'b1;
        if (bus.wb_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      mis_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      if (accept) begin
        op_q    <= bus.ex_opcode;
        addr_q  <= bus.ex_addr;
        wdata_q <= bus.ex_wdata;
        rd_q    <= bus.ex_rd;
        mis_q   <= in_mis;
        wen_q   <= !in_mis && !in_store && (bus.ex_rd != 5'd0);
        data_q  <= in_mem ? '0 : bus.ex_wdata;
      end
      if (state_q == REQ)
        cnt_q <= 4'(RD_LATENCY - 1);
      else if (state_q == WAIT && cnt_q != 4'd0)
        cnt_q <= cnt_q - 4'd1;
      if (state_q == WAIT && cnt_q == 4'd0)
        data_q <= extend(op_q, bus.mem_r_data);
    end
  end

  assign bus.ex_ready    = ex_ready;
  assign bus.inst_opcode = inst_opcode;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_w_ena   = mem_w_ena;
  assign bus.mem_w_data  = mem_w_data;
  assign bus.mem_r_ena   = mem_r_ena;
  assign bus.wb_valid    = wb_valid;
  assign bus.wb_rd       = rd_q;
  assign bus.wb_wen      = wen_q;
  assign bus.wb_data     = data_q;
  assign bus.wb_misalign = mis_q;

endmodule
